// File: rtl/operand_align_pkg.sv
// rtl/operand_align_pkg.sv - shared types and sizing helpers for operand_align_delay
//
// Purpose : default operand width, the valid-plus-data token layout and the
//           helper that sizes the in-flight counter.
// Ports   : none (package)
package operand_align_pkg;

  localparam int DEFAULT_DATA_W = 64;

  // One slot of a delay line: a valid bit above its payload.
  typedef struct packed {
    logic                      vld;
    logic [DEFAULT_DATA_W-1:0] data;
  } token_t;

  // Width needed to count 0..depth inclusive.
  function automatic int inflight_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/operand_align_delay_vld_delay_line.sv
// rtl/operand_align_delay_vld_delay_line.sv - valid-plus-data shift register with bubble zeroing
//
// Purpose : DEPTH-stage free-running shift register. Stage 0 loads the
//           incoming token; bubbles carry zero data so a slot whose valid
//           bit is low always reads 0. A synchronous clear empties every
//           stage in one edge.
// Ports   : clk, rst_n (async active-low), clr (sync clear),
//           in_vld/in_data (stage 0 input), out_vld/out_data (last stage).
module vld_delay_line #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      // Zero the payload of a bubble at entry; later stages just copy.
      data_q[0] <= in_vld ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/operand_align_delay.sv
// rtl/operand_align_delay.sv - fixed-depth alignment delay for operands b and c with sequence tags
//
// Purpose : delays b by B_DEPTH and c by C_DEPTH cycles so each meets its
//           consuming stage, tags every accepted argument with a wrapping
//           sequence id carried alongside c, and counts tokens in the c chain.
// Ports   : clk, rst_n (async active-low), flush (sync drop of in-flight tokens),
//           arg_vld/b/c (argument in), b_shifted_Q/b_vld_Q (delayed b),
//           c_shifted_Q/c_vld_Q/c_seq_Q (delayed c and its id),
//           in_flight (valid tokens currently in the c chain).
module operand_align_delay
  import operand_align_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int B_DEPTH = 3,
  parameter int C_DEPTH = 5,
  parameter int SEQ_W   = 8,
  localparam int IF_W   = inflight_w(C_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              arg_vld,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] b_shifted_Q,
  output logic              b_vld_Q,
  output logic [DATA_W-1:0] c_shifted_Q,
  output logic              c_vld_Q,
  output logic [SEQ_W-1:0]  c_seq_Q,
  output logic [IF_W-1:0]   in_flight
);

  if (B_DEPTH < 1 || B_DEPTH > C_DEPTH || C_DEPTH > 16) begin : g_param_check
    $fatal(1, "operand_align_delay: need 1 <= B_DEPTH <= C_DEPTH <= 16");
  end

  localparam int CW = DATA_W + SEQ_W;

  logic             acc;
  logic [SEQ_W-1:0] seq_cnt;
  logic [CW-1:0]    c_tok_out;

  // An argument presented in a flush cycle is dropped along with the chain.
  assign acc = arg_vld & ~flush;

  vld_delay_line #(
    .WIDTH (DATA_W),
    .DEPTH (B_DEPTH)
  ) u_b_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_vld   (acc),
    .in_data  (b),
    .out_vld  (b_vld_Q),
    .out_data (b_shifted_Q)
  );

  // The sequence id rides in the upper bits of the c payload so it is zeroed
  // on bubbles and cleared on flush exactly like the data.
  vld_delay_line #(
    .WIDTH (CW),
    .DEPTH (C_DEPTH)
  ) u_c_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_vld   (acc),
    .in_data  ({seq_cnt, c}),
    .out_vld  (c_vld_Q),
    .out_data (c_tok_out)
  );

  assign c_shifted_Q = c_tok_out[DATA_W-1:0];
  assign c_seq_Q     = c_tok_out[CW-1 -: SEQ_W];

  // seq_cnt survives flush so ids stay unique across a pipeline drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (acc) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  // Enter and exit are judged on pre-edge state; a simultaneous pair cancels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else if (flush) begin
      in_flight <= '0;
    end else begin
      case ({acc, c_vld_Q})
        2'b10:   in_flight <= in_flight + IF_W'(1);
        2'b01:   in_flight <= in_flight - IF_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_align_delay.sv
// tb/tb_operand_align_delay.sv - self-checking bench for operand_align_delay
module tb_operand_align_delay;

  localparam int DW   = 64;
  localparam int BD   = 3;
  localparam int CD   = 5;
  localparam int SW   = 8;
  localparam int IFW  = $clog2(CD + 1);
  localparam int MAXC = 3000;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          arg_vld;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] b_shifted_Q;
  logic          b_vld_Q;
  logic [DW-1:0] c_shifted_Q;
  logic          c_vld_Q;
  logic [SW-1:0] c_seq_Q;
  logic [IFW-1:0] in_flight;

  operand_align_delay #(
    .DATA_W  (DW),
    .B_DEPTH (BD),
    .C_DEPTH (CD),
    .SEQ_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .arg_vld     (arg_vld),
    .b           (b),
    .c           (c),
    .b_shifted_Q (b_shifted_Q),
    .b_vld_Q     (b_vld_Q),
    .c_shifted_Q (c_shifted_Q),
    .c_vld_Q     (c_vld_Q),
    .c_seq_Q     (c_seq_Q),
    .in_flight   (in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // History of what was presented each cycle: acceptance, payloads, the id
  // assigned at acceptance, and whether that cycle destroyed the pipeline.
  bit            acc_h  [MAXC];
  bit            kill_h [MAXC];
  logic [DW-1:0] b_h    [MAXC];
  logic [DW-1:0] c_h    [MAXC];
  int            seq_h  [MAXC];
  int            n      = 0;
  int            seq_m  = 0;
  int            last_seq = -1;
  int            wraps  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // Token accepted in cycle k is still alive in cycle cur when no flush or
  // reset happened in a later cycle before cur.
  function automatic bit alive(input int k, input int cur);
    if (k < 0) return 1'b0;
    if (!acc_h[k]) return 1'b0;
    for (int j = k + 1; j < cur; j++)
      if (kill_h[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_cycle();
    int kb, kc, cnt;
    kb = n - BD;
    kc = n - CD;
    if (alive(kb, n)) begin
      chk("b_vld", DW'(b_vld_Q), 64'd1);
      chk("b_data", b_shifted_Q, b_h[kb]);
    end else begin
      chk("b_vld", DW'(b_vld_Q), 64'd0);
      chk("b_data", b_shifted_Q, 64'd0);
    end
    if (alive(kc, n)) begin
      chk("c_vld", DW'(c_vld_Q), 64'd1);
      chk("c_data", c_shifted_Q, c_h[kc]);
      chk("c_seq", DW'(c_seq_Q), DW'(seq_h[kc]));
      if (last_seq == 255 && seq_h[kc] == 0) wraps++;
      last_seq = seq_h[kc];
    end else begin
      chk("c_vld", DW'(c_vld_Q), 64'd0);
      chk("c_data", c_shifted_Q, 64'd0);
      chk("c_seq", DW'(c_seq_Q), 64'd0);
    end
    cnt = 0;
    for (int k = n - CD; k < n; k++)
      if (alive(k, n)) cnt++;
    chk("in_flight", DW'(in_flight), DW'(cnt));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_b_vld"}, DW'(b_vld_Q), 64'd0);
    chk({tag, "_b_data"}, b_shifted_Q, 64'd0);
    chk({tag, "_c_vld"}, DW'(c_vld_Q), 64'd0);
    chk({tag, "_c_data"}, c_shifted_Q, 64'd0);
    chk({tag, "_c_seq"}, DW'(c_seq_Q), 64'd0);
    chk({tag, "_in_flight"}, DW'(in_flight), 64'd0);
  endtask

  // Present one cycle of inputs, advance, and check the resulting outputs.
  task automatic step(input bit av, input bit fl, input logic [DW-1:0] bv, input logic [DW-1:0] cv);
    arg_vld   = av;
    flush     = fl;
    b         = bv;
    c         = cv;
    acc_h[n]  = av & ~fl;
    kill_h[n] = fl;
    b_h[n]    = bv;
    c_h[n]    = cv;
    seq_h[n]  = seq_m;
    if (av & ~fl) seq_m = (seq_m + 1) % (1 << SW);
    @(negedge clk);
    n++;
    check_cycle();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    arg_vld = 1'b0;
    b       = '0;
    c       = '0;
    #1;
    check_all_zero("in_reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    check_cycle();

    // Single token
    step(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF);
    idle(8);

    // Back-to-back burst
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(i), 64'(100 + i));
    idle(8);

    // Bubble pattern 1,0,1,1,0
    step(1'b1, 1'b0, 64'hB0, 64'hC0);
    step(1'b0, 1'b0, 64'hFFFF, 64'hFFFF);
    step(1'b1, 1'b0, 64'hB2, 64'hC2);
    step(1'b1, 1'b0, 64'hB3, 64'hC3);
    step(1'b0, 1'b0, 64'hFFFF, 64'hFFFF);
    idle(8);

    // Flush with arg_vld high in the flush cycle
    step(1'b1, 1'b0, 64'h10, 64'h20);
    step(1'b1, 1'b0, 64'h11, 64'h21);
    step(1'b1, 1'b1, 64'h12, 64'h22);
    step(1'b1, 1'b0, 64'h13, 64'h23);
    idle(8);

    // Sequence wrap: long stream of accepts
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, rnd64(), rnd64());
    idle(8);
    chk("seq_wrapped", DW'(wraps), 64'd1);

    // Async reset with tokens in flight
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd64(), rnd64());
    arg_vld   = 1'b0;
    flush     = 1'b0;
    acc_h[n]  = 1'b0;
    kill_h[n] = 1'b1;
    seq_m     = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    n++;
    check_cycle();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 64'hAAAA, 64'hBBBB);
    idle(8);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, rnd64(), rnd64());
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", n);
    $fatal(1, "timeout");
  end

endmodule
